// File: rtl/mem_access_pkg.sv
// mem_access_pkg: funct3 access codes, FSM states and op legality check for the load/store unit
package mem_access_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
  // Misaligned half/word, unsupported size code, or load and store at once.
  function automatic logic is_bad(input logic rd, input logic wr, input logic [2:0] f3, input logic [1:0] off);
    logic mis, bad_f3;
    mis = ((f3 == F3_H || f3 == F3_HU) && off[0]) || (f3 == F3_W && off != 2'b00);
    bad_f3 = wr ? f3 >= 3'b011 : (f3 == 3'b011 || f3[2:1] == 2'b11);
    return (rd && wr) || bad_f3 || mis;
  endfunction
endpackage

// File: rtl/mem_align.sv
// mem_align: store lane replication/byte enables and load shift/extension
// st_f3_i/st_off_i/st_data_i : store size, byte offset, rs2 data
// st_be_o/st_wdata_o         : byte enables and replicated store word
// ld_f3_i/ld_off_i/ld_word_i : load size, byte offset, raw memory word
// ld_data_o                  : aligned, extended load result
module mem_align import mem_access_pkg::*; (
  input  logic [2:0]  st_f3_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  input  logic [2:0]  ld_f3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  output logic [31:0] ld_data_o
);
  logic [31:0] sh;
  always_comb begin
    st_be_o = st_f3_i[1:0] == 2'b00 ? 4'b0001 << st_off_i :
              st_f3_i[1:0] == 2'b01 ? 4'b0011 << {st_off_i[1], 1'b0} : 4'b1111;
    st_wdata_o = st_f3_i[1:0] == 2'b00 ? {4{st_data_i[7:0]}} :
                 st_f3_i[1:0] == 2'b01 ? {2{st_data_i[15:0]}} : st_data_i;
    sh = ld_word_i >> {ld_off_i, 3'b000};
    ld_data_o = ld_f3_i == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                ld_f3_i == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                ld_f3_i == F3_BU ? {24'b0, sh[7:0]} :
                ld_f3_i == F3_HU ? {16'b0, sh[15:0]} : ld_word_i;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: load/store unit running a req/gnt/rvalid handshake with data memory
// clk/rst_n                         : clock, synchronous active-low reset
// ctrl_memread/ctrl_memwrite/funct3 : op type and access size
// alu_result/rdata2                 : byte address, store data
// lsu_stall/load_data/load_valid    : core stall, formatted load result and its pulse
// lsu_err                           : illegal/misaligned op pulse
// dmem_*                            : data memory request and response
module mem_access import mem_access_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrl_memread,
  input  logic        ctrl_memwrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2,
  output logic        lsu_stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        lsu_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);
  state_e state_q, state_d;
  logic [31:0] addr_q, wdata_q, ldata_q, st_wdata, ld_fmt;
  logic [3:0] be_q, st_be;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic we_q, ld_q, err_q, op, bad;
  assign op = ctrl_memread | ctrl_memwrite;
  assign bad = is_bad(ctrl_memread, ctrl_memwrite, funct3, alu_result[1:0]);
  mem_align u_align (
    .st_f3_i    (funct3),
    .st_off_i   (alu_result[1:0]),
    .st_data_i  (rdata2),
    .ld_f3_i    (f3_q),
    .ld_off_i   (off_q),
    .ld_word_i  (dmem_rdata),
    .st_be_o    (st_be),
    .st_wdata_o (st_wdata),
    .ld_data_o  (ld_fmt)
  );
  always_comb begin
    state_d = state_q == IDLE ? (op ? (bad ? DONE : REQ) : IDLE) :
              state_q == REQ  ? (dmem_gnt ? (we_q ? DONE : WAIT) : REQ) :
              state_q == WAIT ? (dmem_rvalid ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      ldata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      ld_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && op) begin
        addr_q  <= {alu_result[31:2], 2'b00};
        be_q    <= ctrl_memwrite ? st_be : 4'b1111;
        wdata_q <= ctrl_memwrite ? st_wdata : '0;
        f3_q    <= funct3;
        off_q   <= alu_result[1:0];
        we_q    <= ctrl_memwrite & ~bad;
        ld_q    <= ctrl_memread & ~bad;
        err_q   <= bad;
      end
      if (state_q == WAIT && dmem_rvalid) ldata_q <= ld_fmt;
    end
  end
  assign lsu_stall  = (state_q == IDLE && op) || state_q == REQ || state_q == WAIT;
  assign dmem_req   = state_q == REQ;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign load_data  = ldata_q;
  assign load_valid = state_q == DONE && ld_q;
  assign lsu_err    = state_q == DONE && err_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed vectors for the load/store unit
module tb_mem_access;
  logic clk = 0, rst_n = 0, ctrl_memread = 0, ctrl_memwrite = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] alu_result = 0, rdata2 = 0, dmem_rdata = 0;
  logic dmem_gnt = 0, dmem_rvalid = 0;
  logic lsu_stall, load_valid, lsu_err, dmem_req, dmem_we;
  logic [31:0] load_data, dmem_addr, dmem_wdata;
  logic [3:0] dmem_be;
  mem_access dut (
    .clk(clk), .rst_n(rst_n), .ctrl_memread(ctrl_memread), .ctrl_memwrite(ctrl_memwrite),
    .funct3(funct3), .alu_result(alu_result), .rdata2(rdata2), .lsu_stall(lsu_stall),
    .load_data(load_data), .load_valid(load_valid), .lsu_err(lsu_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_total = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  int r_stall, r_req, r_lv, r_err, r_err_at, r_first_req, r_done;
  logic [31:0] r_ld, r_addr, r_wdata;
  logic [3:0] r_be;
  logic r_we, r_unstable;
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input int gd, input int rvd, input logic [31:0] word);
    int nreq = 0, wt = 0;
    logic granted = 0;
    bit fin = 0;
    r_stall = 0; r_req = 0; r_lv = 0; r_err = 0; r_err_at = -1; r_first_req = -1; r_done = -1;
    r_ld = 0; r_addr = 0; r_wdata = 0; r_be = 0; r_we = 0; r_unstable = 0;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(posedge clk); #1;
      ctrl_memread = rd; ctrl_memwrite = wr; funct3 = f3; alu_result = a; rdata2 = d;
      dmem_gnt = dmem_req && nreq == gd;
      dmem_rvalid = granted && wt == rvd;
      dmem_rdata = dmem_rvalid ? word : 32'h0;
      #4;
      if (lsu_stall) r_stall++;
      if (dmem_req) begin
        if (r_req == 0) begin
          r_addr = dmem_addr; r_be = dmem_be; r_wdata = dmem_wdata; r_we = dmem_we; r_first_req = cyc;
        end else if (dmem_addr !== r_addr || dmem_be !== r_be || dmem_wdata !== r_wdata || dmem_we !== r_we)
          r_unstable = 1;
        r_req++;
        nreq++;
      end
      if (load_valid) begin r_lv++; r_ld = load_data; end
      if (lsu_err) begin r_err++; r_err_at = k; end
      if (granted) wt++;
      if (dmem_gnt && !wr) granted = 1;
      if (k > 0 && !lsu_stall) begin fin = 1; r_done = cyc; end
    end
    if (!fin) chk("op_timeout", 0, 1);
    dmem_gnt = 0; dmem_rvalid = 0;
  endtask
  task automatic go_idle();
    @(posedge clk); #1;
    ctrl_memread = 0; ctrl_memwrite = 0;
  endtask
  int done1;
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctl", {dmem_req, dmem_we, load_valid, lsu_err, lsu_stall}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be_wd", {dmem_be, dmem_wdata}, 0);
    chk("rst_ld", load_data, 0);
    rst_n = 1;
    // SW zero-wait
    run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0);
    chk("sw_stall", r_stall, 2);
    chk("sw_req", r_req, 1);
    chk("sw_addr", r_addr, 32'h100);
    chk("sw_be", r_be, 4'b1111);
    chk("sw_wdata", r_wdata, 32'hDEADBEEF);
    chk("sw_we", r_we, 1);
    chk("sw_lv_err", {r_lv[3:0], r_err[3:0]}, 0);
    go_idle();
    // LB with gnt delayed 2, rvalid delayed 1
    run_op(1, 0, 3'b000, 32'h203, 0, 2, 1, 32'h80FF0000);
    chk("lb_data", r_ld, 32'hFFFFFF80);
    chk("lb_lv", r_lv, 1);
    chk("lb_stall", r_stall, 6);
    chk("lb_req", r_req, 3);
    chk("lb_stable", r_unstable, 0);
    chk("lb_addr", r_addr, 32'h200);
    chk("lb_be_we", {r_be, 3'b000, r_we}, 32'hF0);
    go_idle();
    run_op(1, 0, 3'b100, 32'h203, 0, 0, 0, 32'h80FF0000);
    chk("lbu_data", r_ld, 32'h00000080);
    chk("lbu_stall", r_stall, 3);
    go_idle();
    // SH upper half
    run_op(0, 1, 3'b001, 32'h302, 32'h0000ABCD, 1, 0, 0);
    chk("sh_be", r_be, 4'b1100);
    chk("sh_wdata", r_wdata, 32'hABCDABCD);
    chk("sh_addr", r_addr, 32'h300);
    chk("sh_stall", r_stall, 3);
    go_idle();
    run_op(1, 0, 3'b101, 32'h302, 0, 0, 0, 32'hABCD1234);
    chk("lhu_data", r_ld, 32'h0000ABCD);
    go_idle();
    run_op(1, 0, 3'b001, 32'h002, 0, 0, 2, 32'h8001FFFF);
    chk("lh_data", r_ld, 32'hFFFF8001);
    chk("lh_stall", r_stall, 5);
    go_idle();
    // illegal ops
    run_op(1, 0, 3'b010, 32'h101, 0, 0, 0, 0);
    chk("lw_mis_req", r_req, 0);
    chk("lw_mis_err", r_err, 1);
    chk("lw_mis_err_at", r_err_at, 1);
    chk("lw_mis_stall", r_stall, 1);
    chk("lw_mis_lv", r_lv, 0);
    go_idle();
    run_op(1, 1, 3'b010, 32'h100, 0, 0, 0, 0);
    chk("both_req", r_req, 0);
    chk("both_err_at", r_err_at, 1);
    chk("both_stall", r_stall, 1);
    go_idle();
    run_op(0, 1, 3'b100, 32'h100, 0, 0, 0, 0);
    chk("sbu_err", r_err, 1);
    chk("sbu_req", r_req, 0);
    go_idle();
    // reset while in WAIT
    @(posedge clk); #1;
    ctrl_memread = 1; funct3 = 3'b010; alu_result = 32'h500;
    @(posedge clk); #1;
    dmem_gnt = 1;
    @(posedge clk); #1;
    dmem_gnt = 0; ctrl_memread = 0; rst_n = 0;
    #4 chk("pre_rst_stall", lsu_stall, 1);
    @(posedge clk); #1;
    rst_n = 1; dmem_rvalid = 1; dmem_rdata = 32'h11223344;
    #4;
    chk("wrst_ctl", {dmem_req, dmem_we, load_valid, lsu_err, lsu_stall}, 0);
    chk("wrst_addr", dmem_addr, 0);
    chk("wrst_be_wd", {dmem_be, dmem_wdata}, 0);
    chk("wrst_ld", load_data, 0);
    @(posedge clk); #1;
    dmem_rvalid = 0;
    #4;
    chk("late_rv_lv", load_valid, 0);
    chk("late_rv_ld", load_data, 0);
    run_op(1, 0, 3'b010, 32'h400, 0, 0, 0, 32'h12345678);
    chk("post_rst_lw", r_ld, 32'h12345678);
    chk("post_rst_lv", r_lv, 1);
    chk("post_rst_stall", r_stall, 3);
    go_idle();
    // back-to-back SB then LW
    run_op(0, 1, 3'b000, 32'h0, 32'h000000A5, 0, 0, 0);
    done1 = r_done;
    chk("b2b_sb_be", r_be, 4'b0001);
    chk("b2b_sb_wd", r_wdata, 32'hA5A5A5A5);
    chk("b2b_sb_req", r_req, 1);
    run_op(1, 0, 3'b010, 32'h4, 0, 0, 0, 32'hCAFEF00D);
    chk("b2b_lw_gap", r_first_req - done1, 2);
    chk("b2b_lw_req", r_req, 1);
    chk("b2b_lw_addr", r_addr, 32'h4);
    chk("b2b_lw_data", r_ld, 32'hCAFEF00D);
    chk("b2b_lw_lv", r_lv, 1);
    go_idle();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
